// File: rtl/lib_arbiter_pkg.sv
// Shared types for the column arbitration blocks: requester FSM states and default widths.
package lib_arbiter_pkg;
  typedef enum logic [1:0] {REQ_IDLE, REQ_BURST, REQ_GAP} req_state_e;
  localparam int DROP_W_DEF = 8;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one per asserted cycle and holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                   cnt_o <= '0;
    else if (inc_i && cnt_o != '1) cnt_o <= cnt_o + ONE;
  end
endmodule

// File: rtl/column_event_requester.sv
// Requester side of the column arbitration handshake: latches column events into a burst,
// retires bits on grant, and parks late events in a shadow register until group release.
module column_event_requester
  import lib_arbiter_pkg::*;
#(
  parameter int Lvl_COLS = 2,
  parameter int DROP_W   = DROP_W_DEF
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [Lvl_COLS-1:0] event_i,
  input  logic [Lvl_COLS-1:0] gnt_i,
  input  logic                grp_release_i,
  output logic [Lvl_COLS-1:0] req_o,
  output logic                busy_o,
  output logic [DROP_W-1:0]   drop_cnt_o,
  output logic                err_o
);
  localparam logic [Lvl_COLS-1:0] ONE = {{(Lvl_COLS-1){1'b0}}, 1'b1};

  req_state_e          state;
  logic [Lvl_COLS-1:0] pend_ff;
  logic [Lvl_COLS-1:0] shadow_ff;
  logic [Lvl_COLS-1:0] gnt_eff;
  logic [Lvl_COLS-1:0] pend_next;
  logic                gnt_multi;
  logic                gnt_orphan;
  logic                drop_inc;

  function automatic logic multi_hot(input logic [Lvl_COLS-1:0] v);
    return |(v & (v - ONE));
  endfunction

  // A multi-hot grant is treated as garbage and retires nothing.
  assign gnt_multi  = multi_hot(gnt_i);
  assign gnt_orphan = (state == REQ_BURST) && |(gnt_i & ~pend_ff);
  assign gnt_eff    = gnt_multi ? '0 : (gnt_i & pend_ff);
  assign pend_next  = pend_ff & ~gnt_eff;
  assign drop_inc   = enable_i && |(event_i & shadow_ff);

  assign req_o  = (state == REQ_BURST) ? pend_ff : '0;
  assign busy_o = (state != REQ_IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= REQ_IDLE;
      pend_ff   <= '0;
      shadow_ff <= '0;
      err_o     <= 1'b0;
    end else begin
      if (gnt_multi || gnt_orphan) err_o <= 1'b1;
      if (!enable_i) begin
        state     <= REQ_IDLE;
        pend_ff   <= '0;
        shadow_ff <= '0;
      end else begin
        unique case (state)
          REQ_IDLE: begin
            if (|(event_i | shadow_ff)) begin
              pend_ff   <= event_i | shadow_ff;
              shadow_ff <= '0;
              state     <= REQ_BURST;
            end
          end
          REQ_BURST: begin
            pend_ff   <= pend_next;
            shadow_ff <= shadow_ff | event_i;
            // Bits the arbiter mask skipped stay pending for the next pass.
            if (grp_release_i && pend_next == '0) state <= REQ_GAP;
          end
          REQ_GAP: begin
            shadow_ff <= shadow_ff | event_i;
            state     <= REQ_IDLE;
          end
          default: state <= REQ_IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(DROP_W)) u_drop_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .inc_i  (drop_inc),
    .cnt_o  (drop_cnt_o)
  );
endmodule

// File: tb/tb_column_event_requester.sv
// Directed bench for column_event_requester with 4 columns; a second instance with a 2-bit
// drop counter shares all inputs to exercise saturation.
module tb_column_event_requester;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] event_v = '0;
  logic [3:0] gnt = '0;
  logic       rel = 1'b0;
  logic [3:0] req, req2;
  logic       busy, busy2, err, err2;
  logic [7:0] drop;
  logic [1:0] drop2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  column_event_requester #(.Lvl_COLS(4), .DROP_W(8)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .event_i(event_v), .gnt_i(gnt),
    .grp_release_i(rel), .req_o(req), .busy_o(busy), .drop_cnt_o(drop), .err_o(err)
  );

  column_event_requester #(.Lvl_COLS(4), .DROP_W(2)) dut_sat (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .event_i(event_v), .gnt_i(gnt),
    .grp_release_i(rel), .req_o(req2), .busy_o(busy2), .drop_cnt_o(drop2), .err_o(err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held while events toggle
    event_v = 4'hF; cyc(); event_v = 4'h0; cyc();
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b0; enable = 1'b1; cyc();
    chk("rst_idle", 32'(busy), 32'h0);

    // Single burst
    event_v = 4'b1010; cyc(); event_v = 4'b0000;
    chk("b1_req", 32'(req), 32'hA);
    chk("b1_busy", 32'(busy), 32'h1);
    gnt = 4'b0010; cyc(); gnt = 4'b0000;
    chk("b1_col1", 32'(req), 32'h8);
    gnt = 4'b1000; rel = 1'b1; cyc(); gnt = 4'b0000; rel = 1'b0;
    chk("b1_gap_req", 32'(req), 32'h0);
    chk("b1_gap_busy", 32'(busy), 32'h1);
    cyc();
    chk("b1_idle", 32'(busy), 32'h0);
    chk("b1_err", 32'(err), 32'h0);

    // Mid-burst events into shadow, duplicate counted once
    event_v = 4'b0100; cyc();
    event_v = 4'b0001; cyc();
    chk("mb_drop0", 32'(drop), 32'h0);
    cyc(); event_v = 4'b0000;
    chk("mb_drop1", 32'(drop), 32'h1);
    chk("mb_req", 32'(req), 32'h4);
    gnt = 4'b0100; rel = 1'b1; cyc(); gnt = 4'b0000; rel = 1'b0;
    chk("mb_gap", 32'(req), 32'h0);
    cyc();
    chk("mb_idle_req", 32'(req), 32'h0);
    chk("mb_idle_busy", 32'(busy), 32'h0);
    cyc();
    chk("mb_reload", 32'(req), 32'h1);
    gnt = 4'b0001; rel = 1'b1; cyc(); gnt = 4'b0000; rel = 1'b0; cyc();

    // Protocol errors: orphan grant, then multi-hot grant
    event_v = 4'b1000; cyc(); event_v = 4'b0000;
    gnt = 4'b0100; cyc(); gnt = 4'b0000;
    chk("pe_err", 32'(err), 32'h1);
    chk("pe_pend", 32'(req), 32'h8);
    gnt = 4'b0110; cyc(); gnt = 4'b0000;
    chk("pe_multi_pend", 32'(req), 32'h8);
    cyc();
    chk("pe_sticky", 32'(err), 32'h1);
    gnt = 4'b1000; rel = 1'b1; cyc(); gnt = 4'b0000; rel = 1'b0; cyc();
    chk("pe_done", 32'(busy), 32'h0);

    // Disable mid-burst
    event_v = 4'b1100; cyc();
    event_v = 4'b0010; cyc(); event_v = 4'b0000;
    enable = 1'b0; cyc();
    chk("dis_req", 32'(req), 32'h0);
    chk("dis_busy", 32'(busy), 32'h0);
    chk("dis_drop", 32'(drop), 32'h1);
    enable = 1'b1; cyc(); cyc();
    chk("dis_shadow_clr", 32'(busy), 32'h0);

    // Saturation: five duplicate events on a shadowed bit
    event_v = 4'b0001; cyc();
    event_v = 4'b1000; cyc();
    for (int i = 0; i < 5; i++) cyc();
    event_v = 4'b0000;
    chk("sat_drop8", 32'(drop), 32'h6);
    chk("sat_drop2", 32'(drop2), 32'h3);
    cyc();
    chk("sat_hold2", 32'(drop2), 32'h3);
    chk("sat_err", 32'(err), 32'h1);

    // Async reset mid-burst
    #2 reset = 1'b1; #1;
    chk("ar_req", 32'(req), 32'h0);
    chk("ar_err", 32'(err), 32'h0);
    chk("ar_drop", 32'(drop), 32'h0);
    cyc(); reset = 1'b0; cyc();

    // Release with a bit still pending keeps the burst alive
    event_v = 4'b0011; cyc(); event_v = 4'b0000;
    rel = 1'b1; cyc(); rel = 1'b0;
    chk("stuck_busy", 32'(busy), 32'h1);
    chk("stuck_req", 32'(req), 32'h3);
    // Grant and event on the same bit
    gnt = 4'b0001; event_v = 4'b0001; cyc(); gnt = 4'b0000; event_v = 4'b0000;
    chk("ge_req", 32'(req), 32'h2);
    gnt = 4'b0010; rel = 1'b1; cyc(); gnt = 4'b0000; rel = 1'b0;
    cyc(); cyc();
    chk("ge_reload", 32'(req), 32'h1);
    chk("ge_err", 32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
